// File: rtl/gb_timer_unit.sv
// gb_timer_unit: DMG/CGB DIV/TIMA/TMA/TAC timer and 0x50 interrupt; `define TIMER_OVF_DELAY_EN for the delayed-reload FSM
module gb_timer_unit #(
  parameter int          TICK_STEP = 4,
  parameter logic [15:0] RESET_DIV = 16'h0000
) (
  input  logic       iClock,
  input  logic       iReset,
  input  logic       iTick,
  input  logic [1:0] iAddr,
  input  logic       iWe,
  input  logic [7:0] iData,
  output logic [7:0] oData,
  output logic       oInterrupt0x50
);
  if (TICK_STEP != 1 && TICK_STEP != 2 && TICK_STEP != 4) begin : g_bad_step
    $error("gb_timer_unit: TICK_STEP must be 1, 2 or 4");
  end
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  tima_q, tima_d, tma_q, tma_d, tima_inc;
  logic [2:0]  tac_q, tac_d;
  logic        sel_q, sel_d, irq_q, irq_d;
  logic        wr_div, wr_tima, wr_tma, wr_tac, inc;
  assign wr_div   = iWe & (iAddr == 2'd0);
  assign wr_tima  = iWe & (iAddr == 2'd1);
  assign wr_tma   = iWe & (iAddr == 2'd2);
  assign wr_tac   = iWe & (iAddr == 2'd3);
  assign tima_inc = tima_q + 8'd1;
  assign inc      = sel_q & ~sel_d;
  // Divider, TMA/TAC next state and the selected divider tap feeding the falling-edge detector
  always_comb begin
    cnt_d = wr_div ? 16'h0000 : iTick ? cnt_q + 16'(TICK_STEP) : cnt_q;
    tma_d = wr_tma ? iData : tma_q;
    tac_d = wr_tac ? iData[2:0] : tac_q;
    sel_d = tac_q[2] & (tac_q[1:0] == 2'd0 ? cnt_q[9] :
                        tac_q[1:0] == 2'd1 ? cnt_q[3] :
                        tac_q[1:0] == 2'd2 ? cnt_q[5] : cnt_q[7]);
  end
`ifdef TIMER_OVF_DELAY_EN
  typedef enum logic [1:0] {RUN, OVF_PEND, RELOAD} state_t;
  state_t state_q, state_d;
  // Overflow FSM: TIMA sits at 00 for one M-cycle, then reloads from TMA and raises the interrupt
  always_comb begin
    state_d = state_q;
    tima_d  = tima_q;
    irq_d   = 1'b0;
    case (state_q)
      RUN: begin
        if (wr_tima) tima_d = iData;
        else if (inc) begin
          tima_d = tima_inc;
          if (tima_q == 8'hFF) state_d = OVF_PEND;
        end
      end
      OVF_PEND: begin
        if (wr_tima) begin
          tima_d  = iData;
          state_d = RUN;
        end else if (iTick) begin
          tima_d  = tma_d;
          irq_d   = 1'b1;
          state_d = RELOAD;
        end else if (inc) tima_d = tima_inc;
      end
      RELOAD: begin
        if (wr_tma) tima_d = iData;
        else if (inc) tima_d = tima_inc;
        if (iTick) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end
`else
  // Immediate reload: the wrapping increment loads TMA and raises the interrupt at once
  always_comb begin
    irq_d  = inc & ~wr_tima & (tima_q == 8'hFF);
    tima_d = wr_tima ? iData : inc ? (tima_q == 8'hFF ? tma_q : tima_inc) : tima_q;
  end
`endif
  // State registers
  always_ff @(posedge iClock) begin
    if (iReset) begin
      cnt_q   <= RESET_DIV;
      tima_q  <= 8'h00;
      tma_q   <= 8'h00;
      tac_q   <= 3'b000;
      sel_q   <= 1'b0;
      irq_q   <= 1'b0;
`ifdef TIMER_OVF_DELAY_EN
      state_q <= RUN;
`endif
    end else begin
      cnt_q   <= cnt_d;
      tima_q  <= tima_d;
      tma_q   <= tma_d;
      tac_q   <= tac_d;
      sel_q   <= sel_d;
      irq_q   <= irq_d;
`ifdef TIMER_OVF_DELAY_EN
      state_q <= state_d;
`endif
    end
  end
  assign oData = iAddr == 2'd0 ? cnt_q[15:8] :
                 iAddr == 2'd1 ? tima_q :
                 iAddr == 2'd2 ? tma_q : {5'h1F, tac_q};
  assign oInterrupt0x50 = irq_q;
endmodule

// File: tb/tb_gb_timer_unit.sv
// tb_gb_timer_unit: table vectors plus corner sequences, checked through a scoreboard queue
module tb_gb_timer_unit;
  logic       iClock = 1'b0;
  logic       iReset = 1'b1;
  logic       iTick = 1'b0;
  logic       iWe = 1'b0;
  logic [1:0] iAddr = 2'd0;
  logic [7:0] iData = 8'h00;
  logic [7:0] od0, od1;
  logic       irq0, irq1;
  int checks = 0;
  int errors = 0;
  typedef struct {
    string      name;
    int         d;
    int         sel;
    logic [7:0] exp;
  } sb_t;
  sb_t q[$];
  typedef struct {
    logic       we;
    logic [1:0] wa;
    logic [7:0] wd;
    logic [1:0] ra;
    logic [7:0] exp;
  } vec_t;
  vec_t vt[9];
  gb_timer_unit #(.TICK_STEP(4), .RESET_DIV(16'hABCC)) dut0 (
    .iClock(iClock), .iReset(iReset), .iTick(iTick), .iAddr(iAddr), .iWe(iWe),
    .iData(iData), .oData(od0), .oInterrupt0x50(irq0)
  );
  gb_timer_unit #(.TICK_STEP(1), .RESET_DIV(16'h0000)) dut1 (
    .iClock(iClock), .iReset(iReset), .iTick(iTick), .iAddr(iAddr), .iWe(iWe),
    .iData(iData), .oData(od1), .oInterrupt0x50(irq1)
  );
  always #5 iClock = ~iClock;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
  task automatic push(input string n, input int d, input int sel, input logic [7:0] e);
    sb_t s;
    s.name = n;
    s.d = d;
    s.sel = sel;
    s.exp = e;
    q.push_back(s);
  endtask
  task automatic drain();
    sb_t s;
    logic [7:0] act;
    while (q.size() > 0) begin
      s = q.pop_front();
      if (s.sel < 4) iAddr = 2'(s.sel);
      #1;
      act = s.sel == 4 ? {7'd0, (s.d == 0 ? irq0 : irq1)} : (s.d == 0 ? od0 : od1);
      checks++;
      if (act !== s.exp) begin
        errors++;
        $display("FAIL %s: got %02h want %02h", s.name, act, s.exp);
      end
    end
  endtask
  task automatic cyc(input logic t, input logic w, input logic [1:0] a, input logic [7:0] dd);
    iTick = t;
    iWe = w;
    iAddr = a;
    iData = dd;
    @(posedge iClock);
    #1;
    iTick = 1'b0;
    iWe = 1'b0;
    drain();
  endtask
  task automatic mtick();
    cyc(1, 0, 0, 8'h00);
    cyc(0, 0, 0, 8'h00);
  endtask
  task automatic rst();
    iReset = 1'b1;
    cyc(0, 0, 0, 8'h00);
    cyc(0, 0, 0, 8'h00);
    iReset = 1'b0;
  endtask
  task automatic base();
    rst();
    cyc(0, 1, 2'd0, 8'h00);
    cyc(0, 1, 2'd3, 8'h05);
    cyc(0, 1, 2'd2, 8'hF0);
    cyc(0, 1, 2'd1, 8'hFE);
  endtask
  task automatic ovf_setup();
    base();
    repeat (3) mtick();
    cyc(1, 0, 0, 8'h00);
    push("tima_ff_tick4", 0, 1, 8'hFF);
    cyc(0, 0, 0, 8'h00);
    repeat (3) mtick();
    cyc(1, 0, 0, 8'h00);
  endtask
  initial begin
    vt[0] = '{1'b0, 2'd0, 8'h00, 2'd0, 8'hAB};
    vt[1] = '{1'b0, 2'd0, 8'h00, 2'd3, 8'hF8};
    vt[2] = '{1'b0, 2'd0, 8'h00, 2'd1, 8'h00};
    vt[3] = '{1'b0, 2'd0, 8'h00, 2'd2, 8'h00};
    vt[4] = '{1'b1, 2'd2, 8'h5A, 2'd2, 8'h5A};
    vt[5] = '{1'b1, 2'd3, 8'hFA, 2'd3, 8'hFA};
    vt[6] = '{1'b1, 2'd1, 8'hC3, 2'd1, 8'hC3};
    vt[7] = '{1'b1, 2'd0, 8'h77, 2'd0, 8'h00};
    vt[8] = '{1'b1, 2'd3, 8'h18, 2'd3, 8'hF8};
    rst();
    push("rst_div", 0, 0, 8'hAB);
    push("rst_tac", 0, 3, 8'hF8);
    push("rst_tima", 0, 1, 8'h00);
    push("rst_irq", 0, 4, 8'h00);
    cyc(0, 0, 0, 8'h00);
    for (int i = 0; i < 9; i++) begin
      push($sformatf("vec%0d", i), 0, int'(vt[i].ra), vt[i].exp);
      push($sformatf("vec%0d_irq", i), 0, 4, 8'h00);
      cyc(0, vt[i].we, vt[i].wa, vt[i].wd);
    end
    rst();
    for (int i = 0; i < 64; i++) begin
      if (i == 11) push("div_before_carry", 0, 0, 8'hAB);
      if (i == 12) push("div_after_carry", 0, 0, 8'hAC);
      if (i == 63) push("div_64_ticks", 0, 0, 8'hAC);
      cyc(1, 0, 0, 8'h00);
    end
    ovf_setup();
`ifdef TIMER_OVF_DELAY_EN
    push("ovf_tima00", 0, 1, 8'h00);
    push("ovf_no_irq", 0, 4, 8'h00);
    cyc(0, 0, 0, 8'h00);
    push("ovf_hold00", 0, 1, 8'h00);
    cyc(0, 0, 0, 8'h00);
    push("ovf_reload", 0, 1, 8'hF0);
    push("ovf_irq", 0, 4, 8'h01);
    cyc(1, 0, 0, 8'h00);
    push("ovf_irq_end", 0, 4, 8'h00);
    push("ovf_tima_keep", 0, 1, 8'hF0);
    cyc(0, 0, 0, 8'h00);
`else
    push("ovf_reload", 0, 1, 8'hF0);
    push("ovf_irq", 0, 4, 8'h01);
    cyc(0, 0, 0, 8'h00);
    push("ovf_irq_end", 0, 4, 8'h00);
    push("ovf_tima_keep", 0, 1, 8'hF0);
    cyc(0, 0, 0, 8'h00);
`endif
    base();
    repeat (3) mtick();
    cyc(1, 0, 0, 8'h00);
    push("wr_beats_inc", 0, 1, 8'h20);
    cyc(0, 1, 2'd1, 8'h20);
    ovf_setup();
    cyc(0, 0, 0, 8'h00);
    iReset = 1'b1;
    push("rstabort_irq", 0, 4, 8'h00);
    push("rstabort_tima", 0, 1, 8'h00);
    cyc(1, 0, 0, 8'h00);
    iReset = 1'b0;
    push("rstabort_irq2", 0, 4, 8'h00);
    cyc(1, 0, 0, 8'h00);
    push("rstabort_irq3", 0, 4, 8'h00);
    cyc(0, 0, 0, 8'h00);
`ifdef TIMER_OVF_DELAY_EN
    ovf_setup();
    cyc(0, 0, 0, 8'h00);
    push("pend_wr_tima", 0, 1, 8'h33);
    push("pend_wr_irq", 0, 4, 8'h00);
    cyc(0, 1, 2'd1, 8'h33);
    push("pend_cancel_irq", 0, 4, 8'h00);
    push("pend_cancel_tima", 0, 1, 8'h33);
    cyc(1, 0, 0, 8'h00);
    push("run_tma_tima", 0, 1, 8'h33);
    push("run_tma", 0, 2, 8'h44);
    cyc(0, 1, 2'd2, 8'h44);
    ovf_setup();
    cyc(0, 0, 0, 8'h00);
    push("rl_enter_tima", 0, 1, 8'hF0);
    push("rl_enter_irq", 0, 4, 8'h01);
    cyc(1, 0, 0, 8'h00);
    push("rl_tima_wr_ignored", 0, 1, 8'hF0);
    cyc(0, 1, 2'd1, 8'h12);
    push("rl_tma_tima", 0, 1, 8'h77);
    push("rl_tma", 0, 2, 8'h77);
    cyc(0, 1, 2'd2, 8'h77);
    cyc(1, 0, 0, 8'h00);
    push("rl_done_tima", 0, 1, 8'h77);
    push("rl_done_tma", 0, 2, 8'h55);
    cyc(0, 1, 2'd2, 8'h55);
    ovf_setup();
    cyc(0, 0, 0, 8'h00);
    push("pend_tma_tima", 0, 1, 8'h9A);
    push("pend_tma", 0, 2, 8'h9A);
    push("pend_tma_irq", 0, 4, 8'h01);
    cyc(1, 1, 2'd2, 8'h9A);
`endif
    rst();
    cyc(0, 1, 2'd0, 8'h00);
    cyc(0, 1, 2'd3, 8'h05);
    mtick();
    mtick();
    push("divwr_tima_lat", 0, 1, 8'h00);
    push("divwr_div", 0, 0, 8'h00);
    cyc(0, 1, 2'd0, 8'hFF);
    push("divwr_tima_inc", 0, 1, 8'h01);
    cyc(0, 0, 0, 8'h00);
    rst();
    cyc(0, 1, 2'd0, 8'h00);
    cyc(0, 1, 2'd3, 8'h01);
    mtick();
    mtick();
    cyc(0, 1, 2'd0, 8'hFF);
    push("divwr_dis_tima", 0, 1, 8'h00);
    push("divwr_dis_div", 0, 0, 8'h00);
    cyc(0, 0, 0, 8'h00);
    rst();
    cyc(0, 1, 2'd3, 8'h04);
    for (int i = 0; i < 1024; i++) begin
      if (i == 1023) push("s1_tima_lat", 1, 1, 8'h00);
      cyc(1, 0, 0, 8'h00);
    end
    push("s1_tima_1024", 1, 1, 8'h01);
    cyc(0, 0, 0, 8'h00);
    repeat (512) cyc(1, 0, 0, 8'h00);
    push("s1_tacwr_lat", 1, 1, 8'h01);
    cyc(0, 1, 2'd3, 8'h00);
    push("s1_tacwr_inc", 1, 1, 8'h02);
    push("s1_tac", 1, 3, 8'hF8);
    cyc(0, 0, 0, 8'h00);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/gb_timer_unit.md
# gb_timer_unit

Cycle-accurate DMG/CGB timer block: free-running internal divider, memory-mapped DIV/TIMA/TMA/TAC registers (FF04–FF07) and the timer-overflow interrupt request (vector 0x50). It replaces the opcode-table M-cycle estimator. Time is driven by a per-M-cycle strobe from the CPU core rather than by per-instruction cycle lookups. It sits between the CPU core tick generator, the IO register decoder and the interrupt controller.

## Interface
- TICK_STEP, 4: T-cycles added to the internal divider per iTick. Legal values are 1, 2 and 4; any other value is a synthesis error.
- RESET_DIV, 16'h0000: value loaded into the 16-bit internal divider on reset. Use 16'hABCC for post-boot DMG state.
- iClock  in  1  system clock.
- iReset  in  1  synchronous, active-high reset, sampled on iClock.
- iTick  in  1  one-iClock strobe marking one CPU M-cycle.
- iAddr  in  2  register select: 0=DIV, 1=TIMA, 2=TMA, 3=TAC.
- iWe  in  1  register write strobe, one iClock wide.
- iData  in  8  write data.
- oData  out  8  read data, combinational from iAddr.
- oInterrupt0x50  out  1  timer interrupt request, one-iClock pulse.

## Operation
- Internal divider rCnt[15:0]:
  - On iTick: rCnt += TICK_STEP, wrapping modulo 2^16.
  - DIV reads rCnt[15:8].
  - Any DIV write clears rCnt to 0, whatever the data. A DIV write on the same clock as iTick: the write wins and rCnt=0.
- TAC:
  - Only bits [2:0] are stored; reads return {5'b11111, TAC[2:0]}.
  - TAC[1:0] selects the divider bit: 00→bit9, 01→bit3, 10→bit5, 11→bit7.
- Increment source:
  - wSel = TAC[2] & rCnt[selected bit], registered every iClock into rSelD.
  - TIMA increments on every iClock where rSelD=1 and wSel=0 (falling edge).
  - A DIV write or TAC write that drops wSel from 1 to 0 therefore increments TIMA. This is intentional DMG behaviour.
- Overflow FSM, states RUN, OVF_PEND, RELOAD:
  - RUN: when a TIMA increment of 8'hFF occurs, TIMA becomes 8'h00 and the FSM goes to OVF_PEND.
  - OVF_PEND: on the next iTick, TIMA←TMA, oInterrupt0x50=1 for that clock, go to RELOAD.
    - A CPU TIMA write while in OVF_PEND stores the written value, cancels the reload and the interrupt, and returns to RUN.
  - RELOAD: lasts until the next iTick, then go to RUN.
    - TIMA writes are ignored.
    - TMA writes update both TMA and TIMA.
  - Any state other than the three above goes to RUN.
- Write/increment collisions:
  - A TIMA write in RUN on the same clock as an increment: the write wins.
  - A TMA write on the same clock as the OVF_PEND→RELOAD transition: TIMA loads the new TMA value.
- oData reads: DIV=rCnt[15:8], TIMA, TMA, {5'h1F, TAC}.

## Timing
- Reset values:
  - rCnt=RESET_DIV, TIMA=00, TMA=00, TAC=000, FSM=RUN.
  - rSelD=0, oInterrupt0x50=0.
  - oData follows iAddr (DIV reads RESET_DIV[15:8]; TAC reads F8).
- Register writes take effect at the iClock edge where iWe=1; they are independent of iTick.
- Increment latency:
  - The rCnt edge that clears the selected bit increments TIMA one iClock later, because of the rSelD register.
  - With back-to-back iTick this is still within the same M-cycle.
- Overflow to interrupt: exactly one iTick after TIMA wraps to 00. TIMA reads 00 for the whole intervening M-cycle.
- An iReset assertion mid-OVF_PEND or mid-RELOAD aborts the reload; no interrupt is emitted.

## Configuration
- TIMER_OVF_DELAY_EN defined: three-state FSM exactly as above; the interrupt and reload are delayed one M-cycle.
- TIMER_OVF_DELAY_EN undefined (simplified model):
  - The FSM is RUN-only.
  - On overflow, TIMA←TMA and oInterrupt0x50 pulses on the same iClock as the wrapping increment.
  - TIMA/TMA write special cases do not apply.

## Test plan
- Reset with RESET_DIV=16'hABCC → DIV reads AB, TAC reads F8, TIMA=00, no interrupt. After 64 iTick (TICK_STEP=4) DIV reads AC.
- TAC=05, TMA=F0, TIMA=FE, then 8 iTick → TIMA=00 after tick 8. With the macro on, tick 9 gives TIMA=F0 plus a 1-clock oInterrupt0x50 pulse.
- Same setup; write TIMA=33 during OVF_PEND → TIMA=33, no interrupt, FSM in RUN.
- Same setup; write TMA=77 during RELOAD → TIMA=77 and TMA=77. A TIMA=12 write during RELOAD is ignored.
- TAC=05, advance rCnt until bit3=1, then write DIV → TIMA +1, DIV=00. Repeat with TAC=01 (disabled) → TIMA unchanged.
- TAC=04, TICK_STEP=1, 1024 iTick → TIMA=01. TAC write 04→00 while rCnt[9]=1 → TIMA +1.
